apb_req_arbiter: RTL

Round-robin arbiter that shares the single request/response port of the APB master between `NUM_REQ` upstream requesters, such as several AXI-to-request converters. Exactly one transaction is outstanding at any time. The grant is held from arbitration until the matching response returns. A response watchdog prevents a stalled APB slave from locking out every requester. The block sits between the request converters and `apb_master` inside the bridge core.

---
 rtl/apb_req_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master request/response port between
// NUM_REQ requesters. One transaction outstanding; grant held until response.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   up_req_valid/ready   per-requester request handshake
//   up_req_addr/wdata    flattened 32-bit fields, requester i at [32i+:32]
//   up_req_write         per-requester direction (1 = write)
//   up_resp_done         one-cycle response pulse to the granted requester
//   up_resp_rdata/err    response data / timeout flag, valid with done
//   req_valid/ready      request handshake to apb_master
//   req_addr/wdata/write request fields to apb_master
//   resp_rdata/done      completion from apb_master
module apb_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    up_req_valid,
    output logic [NUM_REQ-1:0]    up_req_ready,
    input  logic [NUM_REQ*32-1:0] up_req_addr,
    input  logic [NUM_REQ*32-1:0] up_req_wdata,
    input  logic [NUM_REQ-1:0]    up_req_write,
    output logic [NUM_REQ-1:0]    up_resp_done,
    output logic [31:0]           up_resp_rdata,
    output logic                  up_resp_err,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [31:0]           req_addr,
    output logic [31:0]           req_wdata,
    output logic                  req_write,
    input  logic [31:0]           resp_rdata,
    input  logic                  resp_done
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CEXP_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CEXP  = CW'(CEXP_I);
    localparam logic [GW-1:0] GLAST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_rr_ptr;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_resp_done;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_found;
    logic [GW-1:0]       w_pick;
    int                  w_idx;
    logic [GW-1:0]       w_next_ptr;
    logic                w_timeout;
    logic                w_in_req;
    int                  w_sel;
    logic [NUM_REQ-1:0]  w_ready;

    // First valid requester at or after r_rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && up_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    assign w_next_ptr = (r_grant == GLAST) ? '0 : r_grant + 1'b1;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == CEXP);
    assign w_in_req   = (r_state == S_REQ);
    assign w_sel      = int'(r_grant);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_resp_done  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses.
            r_resp_done  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != CMAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A real response beats a coincident timeout.
                    if (resp_done) begin
                        r_resp_done[r_grant] <= 1'b1;
                        r_resp_rdata         <= resp_rdata;
                        r_rr_ptr             <= w_next_ptr;
                        r_state              <= S_IDLE;
                    end else if (w_timeout) begin
                        r_resp_done[r_grant] <= 1'b1;
                        r_resp_err           <= 1'b1;
                        r_rr_ptr             <= w_next_ptr;
                        r_state              <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_in_req) begin
            w_ready[r_grant] = req_ready;
        end
    end

    assign up_req_ready  = w_ready;
    assign req_valid     = w_in_req;
    assign req_addr      = w_in_req ? up_req_addr[w_sel*32 +: 32] : '0;
    assign req_wdata     = w_in_req ? up_req_wdata[w_sel*32 +: 32] : '0;
    assign req_write     = w_in_req & up_req_write[r_grant];
    assign up_resp_done  = r_resp_done;
    assign up_resp_rdata = r_resp_rdata;
    assign up_resp_err   = r_resp_err;

endmodule
